shift_reg_seq: RTL and testbench

Parametrised multi-cycle shift/rotate register, the next generation of the team's 4-bit load/shift register. It adds configurable width, a per-cycle shift step limit, arithmetic and rotate modes, a serial fill bit, and a valid/ready command handshake with busy and done status. It sits in datapath sequencers where wide shifts must be split over several cycles to meet timing.

---
 rtl/shift_reg_seq.sv | 136 +++++++++++++
 tb/tb_shift_reg_seq.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/shift_reg_seq.sv
// shift_reg_seq: multi-cycle shift/rotate register with a valid/ready command port.
// Wide shifts are split into steps of at most STEP bits per clock.
// Optional feature macro: SHIFT_REG_SEQ_ROTATE_EN (builds ROL/ROR; otherwise they act as NOP).
module shift_reg_seq #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] d_in,
    input  logic [CNT_W-1:0] s_cnt,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_SHR  = 3'b011;
    localparam logic [2:0] OP_SRA  = 3'b100;
`ifdef SHIFT_REG_SEQ_ROTATE_EN
    localparam logic [2:0] OP_ROL  = 3'b101;
    localparam logic [2:0] OP_ROR  = 3'b110;
    localparam logic [CNT_W:0] WIDTH_C = (CNT_W+1)'(WIDTH);
`endif
    localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d, sh_res;
    logic [CNT_W-1:0] rem_q, rem_d, sh_n, k;
    logic [2:0]       op_q, op_d, sh_op;
    logic             ser_q, ser_d, sh_ser;
    logic             done_q, done_d;
    logic             is_shift;

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q == S_SHIFT);
    assign done      = done_q;
    assign q         = q_q;

    // Opcode decode of the incoming command: which ops take the stepping path
    always_comb begin
        is_shift = 1'b0;
        case (op)
            OP_SHL, OP_SHR, OP_SRA: is_shift = 1'b1;
`ifdef SHIFT_REG_SEQ_ROTATE_EN
            OP_ROL, OP_ROR:         is_shift = 1'b1;
`endif
            default:                is_shift = 1'b0;
        endcase
    end

    // One step of the shifter; in IDLE it works on the live command so the
    // first step lands on the accept edge, in SHIFT on the latched copy
    always_comb begin
        sh_op  = (state_q == S_IDLE) ? op     : op_q;
        sh_ser = (state_q == S_IDLE) ? ser_in : ser_q;
        sh_n   = (state_q == S_IDLE) ? s_cnt  : rem_q;
        k      = (sh_n < STEP_C) ? sh_n : STEP_C;
        sh_res = q_q;
        case (sh_op)
            OP_SHL: sh_res = (q_q << k) | (sh_ser ? ~({WIDTH{1'b1}} << k) : '0);
            OP_SHR: sh_res = (q_q >> k) | (sh_ser ? ~({WIDTH{1'b1}} >> k) : '0);
            OP_SRA: sh_res = WIDTH'($signed(q_q) >>> k);
`ifdef SHIFT_REG_SEQ_ROTATE_EN
            OP_ROL: sh_res = (q_q << k) | (q_q >> (WIDTH_C - {1'b0, k}));
            OP_ROR: sh_res = (q_q >> k) | (q_q << (WIDTH_C - {1'b0, k}));
`endif
            default: sh_res = q_q;
        endcase
    end

    // Next-state / datapath control for the IDLE/SHIFT sequencer
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        rem_d   = rem_q;
        op_d    = op_q;
        ser_d   = ser_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d  = op;
                    ser_d = ser_in;
                    if (op == OP_LOAD) begin
                        q_d    = d_in;
                        done_d = 1'b1;
                    end else if (is_shift && (s_cnt != '0)) begin
                        q_d     = sh_res;
                        rem_d   = s_cnt - k;
                        done_d  = (rem_d == '0);
                        state_d = (rem_d == '0) ? S_IDLE : S_SHIFT;
                    end else begin
                        // NOP, reserved, disabled rotate or zero-length shift
                        done_d = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                q_d   = sh_res;
                rem_d = rem_q - k;
                if (rem_d == '0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and data registers; reset abandons any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            rem_q   <= '0;
            op_q    <= '0;
            ser_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
            ser_q   <= ser_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_shift_reg_seq.sv
// Directed bench for shift_reg_seq: a STEP=1 and a STEP=3 instance sharing
// command inputs, each with its own cmd_valid.
module tb_shift_reg_seq;
    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_valid3;
    logic [2:0] op;
    logic [7:0] d_in;
    logic [2:0] s_cnt;
    logic       ser_in;
    logic       cmd_ready, busy, done;
    logic       cmd_ready3, busy3, done3;
    logic [7:0] q, q3;

    int checks   = 0;
    int failures = 0;

    localparam logic [2:0] NOP = 3'b000, LOAD = 3'b001, SHL = 3'b010, SHR = 3'b011,
                           SRA = 3'b100, ROR = 3'b110;

    shift_reg_seq #(.WIDTH(8), .STEP(1)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .op(op), .d_in(d_in), .s_cnt(s_cnt), .ser_in(ser_in),
        .q(q), .busy(busy), .done(done)
    );

    shift_reg_seq #(.WIDTH(8), .STEP(3)) dut3 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
        .op(op), .d_in(d_in), .s_cnt(s_cnt), .ser_in(ser_in),
        .q(q3), .busy(busy3), .done(done3)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // status = {cmd_ready, busy, done}
    task automatic chk_st(input string tag, input logic r, input logic b, input logic d);
        chk(tag, {5'b0, cmd_ready, busy, done}, {5'b0, r, b, d});
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b1; cmd_valid3 = 1'b0;
        op = LOAD; d_in = 8'hFF; s_cnt = 3'd0; ser_in = 1'b0;
        // reset with a LOAD held on cmd_valid: must be ignored
        tick(); tick();
        chk("reset_q", q, 8'h00);
        chk_st("reset_status", 1'b1, 1'b0, 1'b0);
        cmd_valid = 1'b0; rst = 1'b0;
        tick();
        chk("post_reset_q", q, 8'h00);

        // LOAD 0xA5
        chk_st("load_ready_before", 1'b1, 1'b0, 1'b0);
        cmd_valid = 1'b1; op = LOAD; d_in = 8'hA5;
        tick(); cmd_valid = 1'b0;
        chk("load_q", q, 8'hA5);
        chk_st("load_done", 1'b1, 1'b0, 1'b1);
        tick();
        chk_st("load_done_clear", 1'b1, 1'b0, 1'b0);

        // SHL 3 with ser_in=1, STEP=1; commands during busy ignored, ser_in latched
        cmd_valid = 1'b1; op = SHL; s_cnt = 3'd3; ser_in = 1'b1;
        tick();
        chk("shl_step1", q, 8'h4B);
        chk_st("shl_busy1", 1'b0, 1'b1, 1'b0);
        op = LOAD; d_in = 8'h00; ser_in = 1'b0;
        tick();
        chk("shl_step2", q, 8'h97);
        chk_st("shl_busy2", 1'b0, 1'b1, 1'b0);
        cmd_valid = 1'b0;
        tick();
        chk("shl_step3", q, 8'h2F);
        chk_st("shl_done", 1'b1, 1'b0, 1'b1);
        tick();
        chk("shl_hold", q, 8'h2F);
        chk_st("shl_done_clear", 1'b1, 1'b0, 1'b0);

        // STEP=3 instance: LOAD 0x96, SRA 5 -> 0xF2, 0xFC
        cmd_valid3 = 1'b1; op = LOAD; d_in = 8'h96;
        tick();
        chk("s3_load", q3, 8'h96);
        op = SRA; s_cnt = 3'd5;
        tick(); cmd_valid3 = 1'b0;
        chk("s3_sra_step1", q3, 8'hF2);
        chk("s3_sra_busy", {5'b0, cmd_ready3, busy3, done3}, 8'b010);
        tick();
        chk("s3_sra_step2", q3, 8'hFC);
        chk("s3_sra_done", {5'b0, cmd_ready3, busy3, done3}, 8'b101);
        tick();
        chk("s3_done_clear", {7'b0, done3}, 8'h00);

        // ROR 4 on 0x3C
        cmd_valid = 1'b1; op = LOAD; d_in = 8'h3C;
        tick();
        op = ROR; s_cnt = 3'd4;
        tick(); cmd_valid = 1'b0;
`ifdef SHIFT_REG_SEQ_ROTATE_EN
        chk("ror_step1", q, 8'h1E);
        chk_st("ror_busy", 1'b0, 1'b1, 1'b0);
        tick(); tick(); tick();
        chk("ror_final", q, 8'hC3);
        chk_st("ror_done", 1'b1, 1'b0, 1'b1);
`else
        chk("ror_nop_q", q, 8'h3C);
        chk_st("ror_nop_done", 1'b1, 1'b0, 1'b1);
        tick();
        chk("ror_nop_hold", q, 8'h3C);
        chk_st("ror_nop_idle", 1'b1, 1'b0, 1'b0);
`endif
        tick();

        // reset abort: LOAD 0xFF, SHR 7, reset after 2 edges
        cmd_valid = 1'b1; op = LOAD; d_in = 8'hFF;
        tick();
        op = SHR; s_cnt = 3'd7; ser_in = 1'b0;
        tick(); cmd_valid = 1'b0;
        tick();
        chk("abort_mid_q", q, 8'h3F);
        rst = 1'b1;
        tick(); rst = 1'b0;
        chk("abort_q", q, 8'h00);
        chk_st("abort_status", 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("abort_no_done", {7'b0, done}, 8'h00);
        end

        // back-to-back: LOAD 0x01, SHL 0, LOAD 0x80
        cmd_valid = 1'b1; op = LOAD; d_in = 8'h01;
        tick();
        chk("b2b_q1", q, 8'h01);
        chk_st("b2b_st1", 1'b1, 1'b0, 1'b1);
        op = SHL; s_cnt = 3'd0; ser_in = 1'b1;
        tick();
        chk("b2b_q2", q, 8'h01);
        chk_st("b2b_st2", 1'b1, 1'b0, 1'b1);
        op = LOAD; d_in = 8'h80;
        tick(); cmd_valid = 1'b0;
        chk("b2b_q3", q, 8'h80);
        chk_st("b2b_st3", 1'b1, 1'b0, 1'b1);
        tick();
        chk_st("b2b_end", 1'b1, 1'b0, 1'b0);

        // reserved opcode 111: NOP with done pulse
        cmd_valid = 1'b1; op = 3'b111; s_cnt = 3'd3;
        tick(); cmd_valid = 1'b0;
        chk("rsv_q", q, 8'h80);
        chk_st("rsv_done", 1'b1, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
